// File: rtl/game_pkg.sv
// Shared constants, types and the scheduler state encoding for the bullet-bill logic.
package game_pkg;

  // Screen geometry in pixels/blocks.
  localparam int unsigned BSIZE     = 40;
  localparam int unsigned GRID_COLS = 16;
  localparam int unsigned GRID_ROWS = 12;

  // Enemy (ddaver) grid dimensions.
  localparam int unsigned DDAVER_ROWS = 5;
  localparam int unsigned DDAVER_COLS = 6;

  // Bullet slot parameters; NUM_BULLETS is fixed by the graphics path.
  localparam int unsigned NUM_BULLETS = 3;
  localparam int unsigned SPAWN_COL   = 2;
  localparam int unsigned LAST_COL    = 15;
  localparam int unsigned MAX_ROW     = 10;

  // RGB444 color; zero means empty.
  typedef logic [11:0] color_t;

  typedef enum logic [2:0] {
    StIdle,
    StAdv0,
    StAdv1,
    StAdv2,
    StSpawn
  } sched_state_e;

endpackage

// File: rtl/bullet_collision_check.sv
// Combinational one-step advance and collision test for a single bullet slot.
module bullet_collision_check
  import game_pkg::*;
(
  input  color_t      color_i,
  input  logic [3:0]  x_i,
  input  logic [3:0]  y_i,
  input  color_t      ddavers_i [0:DDAVER_ROWS-1][0:DDAVER_COLS-1],
  output logic [3:0]  next_x_o,
  output logic        free_o,
  output logic        hit_o,
  output logic        match_o,
  output logic [2:0]  row_o,
  output logic [2:0]  col_o
);

  logic [4:0] x_inc;
  logic [3:0] col_full;
  logic [2:0] row_idx;
  logic [2:0] col_idx;
  color_t     enemy;

  // Enemies sit on odd block rows and even block columns starting at column 4.
  always_comb begin
    x_inc    = {1'b0, x_i} + 5'd1;
    row_idx  = y_i[3:1];
    col_full = x_inc[4:1] - 4'd2;
    col_idx  = col_full[2:0];
    enemy    = '0;
    if (row_idx < 3'(DDAVER_ROWS) && col_idx < 3'(DDAVER_COLS)) begin
      enemy = ddavers_i[row_idx][col_idx];
    end

    next_x_o = x_inc[3:0];
    free_o   = 1'b0;
    hit_o    = 1'b0;
    match_o  = 1'b0;
    row_o    = row_idx;
    col_o    = col_idx;

    if (color_i != '0) begin
      if (x_inc > 5'(LAST_COL)) begin
        free_o = 1'b1;
      end else if (y_i[0] && !x_inc[0] && x_inc >= 5'd4 && enemy != '0) begin
        hit_o   = 1'b1;
        free_o  = 1'b1;
        match_o = (enemy == color_i);
      end
    end
  end

endmodule

// File: rtl/bullet_bill_scheduler.sv
// Owns the bullet slots: spawns on fire, advances on tick and reports enemy hits.
module bullet_bill_scheduler
  import game_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic        fire_i,
  input  logic [11:0] fire_color_i,
  input  logic [3:0]  blockieee_i,
  input  logic [11:0] ddavers_i [0:DDAVER_ROWS-1][0:DDAVER_COLS-1],
  output logic [11:0] bullet_bill_color_o [0:NUM_BULLETS-1],
  output logic [3:0]  bullet_bill_x_loc_o [0:NUM_BULLETS-1],
  output logic [3:0]  bullet_bill_y_loc_o [0:NUM_BULLETS-1],
  output logic        hit_valid_o,
  output logic [2:0]  hit_row_o,
  output logic [2:0]  hit_col_o,
  output logic        hit_match_o,
  output logic [7:0]  kill_count_o,
  output logic        fire_drop_o,
  output logic        busy_o
);

  sched_state_e state_q, state_d;

  color_t     color_q [NUM_BULLETS];
  color_t     color_d [NUM_BULLETS];
  logic [3:0] x_q     [NUM_BULLETS];
  logic [3:0] x_d     [NUM_BULLETS];
  logic [3:0] y_q     [NUM_BULLETS];
  logic [3:0] y_d     [NUM_BULLETS];

  logic       tick_pend_q, tick_pend_d;
  logic       fire_pend_q, fire_pend_d;
  color_t     pend_color_q, pend_color_d;
  logic [3:0] pend_row_q, pend_row_d;

  logic       hit_valid_q, hit_valid_d;
  logic [2:0] hit_row_q, hit_row_d;
  logic [2:0] hit_col_q, hit_col_d;
  logic       hit_match_q, hit_match_d;
  logic [7:0] kill_q, kill_d;
  logic       fire_drop_q, fire_drop_d;

  logic [1:0] sel;
  logic [3:0] chk_next_x;
  logic       chk_free, chk_hit, chk_match;
  logic [2:0] chk_row, chk_col;
  logic       tick_consumed, fire_consumed, found;

  // Slot being advanced follows the ADVn state.
  always_comb begin
    case (state_q)
      StAdv1:  sel = 2'd1;
      StAdv2:  sel = 2'd2;
      default: sel = 2'd0;
    endcase
  end

  bullet_collision_check u_check (
    .color_i   (color_q[sel]),
    .x_i       (x_q[sel]),
    .y_i       (y_q[sel]),
    .ddavers_i (ddavers_i),
    .next_x_o  (chk_next_x),
    .free_o    (chk_free),
    .hit_o     (chk_hit),
    .match_o   (chk_match),
    .row_o     (chk_row),
    .col_o     (chk_col)
  );

  // Next-state: FSM sequencing, slot updates, hit reporting and request latching.
  always_comb begin
    state_d       = state_q;
    color_d       = color_q;
    x_d           = x_q;
    y_d           = y_q;
    tick_pend_d   = tick_pend_q;
    fire_pend_d   = fire_pend_q;
    pend_color_d  = pend_color_q;
    pend_row_d    = pend_row_q;
    hit_valid_d   = 1'b0;
    hit_row_d     = hit_row_q;
    hit_col_d     = hit_col_q;
    hit_match_d   = hit_match_q;
    kill_d        = kill_q;
    fire_drop_d   = 1'b0;
    tick_consumed = 1'b0;
    fire_consumed = 1'b0;
    found         = 1'b0;

    case (state_q)
      StIdle: begin
        if (tick_i || tick_pend_q) begin
          state_d       = StAdv0;
          tick_pend_d   = 1'b0;
          tick_consumed = 1'b1;
        end else if (fire_i || fire_pend_q) begin
          // Spawn reads the pending registers, which capture fire_i on this edge.
          state_d = StSpawn;
        end
      end
      StAdv0, StAdv1, StAdv2: begin
        if (color_q[sel] != '0) begin
          if (chk_free) begin
            color_d[sel] = '0;
            x_d[sel]     = '0;
            y_d[sel]     = '0;
          end else begin
            x_d[sel] = chk_next_x;
          end
          if (chk_hit) begin
            hit_valid_d = 1'b1;
            hit_row_d   = chk_row;
            hit_col_d   = chk_col;
            hit_match_d = chk_match;
            if (chk_match && kill_q != 8'hFF) begin
              kill_d = kill_q + 8'd1;
            end
          end
        end
        if (state_q == StAdv0) begin
          state_d = StAdv1;
        end else if (state_q == StAdv1) begin
          state_d = StAdv2;
        end else begin
          state_d = fire_pend_q ? StSpawn : StIdle;
        end
      end
      StSpawn: begin
        fire_consumed = 1'b1;
        fire_pend_d   = 1'b0;
        if (pend_color_q == '0 || pend_row_q > 4'(MAX_ROW)) begin
          fire_drop_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!found && color_q[i] == '0) begin
              found      = 1'b1;
              color_d[i] = pend_color_q;
              x_d[i]     = 4'(SPAWN_COL);
              y_d[i]     = pend_row_q;
            end
          end
          if (!found) begin
            fire_drop_d = 1'b1;
          end
        end
        if (tick_pend_q) begin
          state_d       = StAdv0;
          tick_pend_d   = 1'b0;
          tick_consumed = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // One-deep tick buffer; a tick on the consuming cycle is lost.
    if (tick_i && state_q != StIdle && !tick_consumed) begin
      tick_pend_d = 1'b1;
    end

    // Newest fire wins; overwriting an unconsumed request drops the old one.
    if (fire_i) begin
      if (fire_pend_q && !fire_consumed) begin
        fire_drop_d = 1'b1;
      end
      fire_pend_d  = 1'b1;
      pend_color_d = fire_color_i;
      pend_row_d   = blockieee_i;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        color_q[i] <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      tick_pend_q  <= 1'b0;
      fire_pend_q  <= 1'b0;
      pend_color_q <= '0;
      pend_row_q   <= '0;
      hit_valid_q  <= 1'b0;
      hit_row_q    <= '0;
      hit_col_q    <= '0;
      hit_match_q  <= 1'b0;
      kill_q       <= '0;
      fire_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tick_pend_q  <= tick_pend_d;
      fire_pend_q  <= fire_pend_d;
      pend_color_q <= pend_color_d;
      pend_row_q   <= pend_row_d;
      hit_valid_q  <= hit_valid_d;
      hit_row_q    <= hit_row_d;
      hit_col_q    <= hit_col_d;
      hit_match_q  <= hit_match_d;
      kill_q       <= kill_d;
      fire_drop_q  <= fire_drop_d;
    end
  end

  assign bullet_bill_color_o = color_q;
  assign bullet_bill_x_loc_o = x_q;
  assign bullet_bill_y_loc_o = y_q;
  assign hit_valid_o         = hit_valid_q;
  assign hit_row_o           = hit_row_q;
  assign hit_col_o           = hit_col_q;
  assign hit_match_o         = hit_match_q;
  assign kill_count_o        = kill_q;
  assign fire_drop_o         = fire_drop_q;
  assign busy_o              = (state_q != StIdle);

endmodule

// File: tb/tb_bullet_bill_scheduler.sv
// Self-checking bench for bullet_bill_scheduler: vector table, corner sequences, random vs model.
module tb_bullet_bill_scheduler;

  logic        clk = 1'b0;
  logic        reset, tick, fire;
  logic [11:0] fire_color;
  logic [3:0]  blockieee;
  logic [11:0] ddavers [0:4][0:5];
  logic [11:0] bb_color [0:2];
  logic [3:0]  bb_x [0:2];
  logic [3:0]  bb_y [0:2];
  logic        hit_valid, hit_match, fire_drop, busy;
  logic [2:0]  hit_row, hit_col;
  logic [7:0]  kill_count;

  bullet_bill_scheduler dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .tick_i              (tick),
    .fire_i              (fire),
    .fire_color_i        (fire_color),
    .blockieee_i         (blockieee),
    .ddavers_i           (ddavers),
    .bullet_bill_color_o (bb_color),
    .bullet_bill_x_loc_o (bb_x),
    .bullet_bill_y_loc_o (bb_y),
    .hit_valid_o         (hit_valid),
    .hit_row_o           (hit_row),
    .hit_col_o           (hit_col),
    .hit_match_o         (hit_match),
    .kill_count_o        (kill_count),
    .fire_drop_o         (fire_drop),
    .busy_o              (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-operation observations.
  int         op_hits, op_drops, hit_at;
  logic [2:0] last_row, last_col;
  logic       last_match;

  // Reference model of the slots.
  logic [11:0] m_col [3];
  logic [3:0]  m_x [3];
  logic [3:0]  m_y [3];
  int          m_kill, m_hits, m_drops;

  typedef struct {
    logic [3:0]  row;
    int          steps;
    int          er, ec;
    logic [11:0] enemy, color;
    logic        exp_hit;
    logic [2:0]  exp_hr, exp_hc;
    logic        exp_match;
    logic [11:0] exp_col;
    logic [3:0]  exp_x;
    int          exp_kill;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_slot(input string name, input int s, input logic [11:0] c,
                            input logic [3:0] x, input logic [3:0] y);
    check($sformatf("%s slot%0d", name, s), {bb_color[s], bb_x[s], bb_y[s]}, {c, x, y});
  endtask

  task automatic clear_dd();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++) ddavers[r][c] = '0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_col[s] = '0;
      m_x[s]   = '0;
      m_y[s]   = '0;
    end
    m_kill = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    fire  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Game-step rules applied to every live slot in slot order.
  task automatic model_tick();
    for (int s = 0; s < 3; s++) begin
      if (m_col[s] != 0) begin
        int nx;
        int y;
        logic [11:0] e;
        nx = int'(m_x[s]) + 1;
        y  = int'(m_y[s]);
        e  = '0;
        if (y % 2 == 1 && nx % 2 == 0 && nx >= 4 && nx <= 15) e = ddavers[3'(y / 2)][3'(nx / 2 - 2)];
        if (nx > 15) begin
          m_col[s] = '0; m_x[s] = '0; m_y[s] = '0;
        end else if (e != 0) begin
          m_hits++;
          if (e == m_col[s] && m_kill < 255) m_kill++;
          m_col[s] = '0; m_x[s] = '0; m_y[s] = '0;
        end else begin
          m_x[s] = 4'(nx);
        end
      end
    end
  endtask

  task automatic model_fire(input logic [11:0] c, input logic [3:0] r);
    bit placed;
    placed = 0;
    if (c != 0 && r <= 10) begin
      for (int s = 0; s < 3; s++) begin
        if (!placed && m_col[s] == 0) begin
          placed = 1;
          m_col[s] = c; m_x[s] = 4'd2; m_y[s] = r;
        end
      end
    end
    if (!placed) m_drops++;
  endtask

  // Issue a tick and/or fire from idle and wait (bounded) until the DUT is idle again.
  task automatic run_op(input logic t, input logic f, input logic [11:0] c, input logic [3:0] r);
    bit seen, done;
    seen = 0; done = 0;
    op_hits = 0; op_drops = 0; hit_at = -1;
    tick = t; fire = f; fire_color = c; blockieee = r;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      tick = 1'b0;
      fire = 1'b0;
      if (hit_valid) begin
        op_hits++;
        hit_at     = i;
        last_row   = hit_row;
        last_col   = hit_col;
        last_match = hit_match;
      end
      if (fire_drop) op_drops++;
      if (busy) seen = 1;
      else if (seen) done = 1;
    end
    check("op completes", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [11:0] pick_color();
    case ($urandom_range(0, 3))
      0: return 12'h000;
      1: return 12'hF00;
      2: return 12'h0F0;
      default: return 12'h00F;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] trace;
    logic       busy_seen;
    reset = 1'b1; tick = 1'b0; fire = 1'b0; fire_color = '0; blockieee = '0;
    clear_dd();

    vecs[0] = '{4'd3, 1, 1, 0, 12'hF00, 12'hF00, 1, 3'd1, 3'd0, 1, 12'h000, 4'd0, 1};
    vecs[1] = '{4'd3, 1, 1, 0, 12'h0F0, 12'hF00, 1, 3'd1, 3'd0, 0, 12'h000, 4'd0, 0};
    vecs[2] = '{4'd2, 13, 0, 0, 12'h000, 12'h0F0, 0, 3'd0, 3'd0, 0, 12'h000, 4'd0, 0};
    vecs[3] = '{4'd2, 4, 1, 1, 12'hF00, 12'hF00, 0, 3'd0, 3'd0, 0, 12'hF00, 4'd7, 0};
    vecs[4] = '{4'd9, 9, 4, 4, 12'h00F, 12'h00F, 1, 3'd4, 3'd4, 1, 12'h000, 4'd0, 1};
    vecs[5] = '{4'd5, 2, 2, 0, 12'h00F, 12'h00F, 0, 3'd0, 3'd0, 0, 12'h00F, 4'd5, 0};
    vecs[6] = '{4'd1, 11, 0, 5, 12'hF00, 12'h0F0, 1, 3'd0, 3'd5, 0, 12'h000, 4'd0, 0};

    // Reset state.
    do_reset();
    for (int s = 0; s < 3; s++) check_slot("reset", s, 12'h0, 4'd0, 4'd0);
    check("reset flags", {hit_valid, hit_row, hit_col, hit_match, fire_drop, busy}, 32'd0);
    check("reset kill", kill_count, 32'd0);

    // Fire latency from idle: slot appears two cycles after the fire cycle.
    fire = 1'b1; fire_color = 12'hF00; blockieee = 4'd3;
    @(negedge clk);
    fire = 1'b0;
    check("spawn early", {bb_color[0], 3'd0, busy}, {12'h000, 3'd0, 1'b1});
    @(negedge clk);
    check_slot("spawn", 0, 12'hF00, 4'd2, 4'd3);
    check("spawn others", {bb_color[1], bb_color[2], 7'd0, busy}, 32'd0);

    // Table of single-bullet advance/collision cases.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_dd();
      run_op(1'b0, 1'b1, vecs[v].color, vecs[v].row);
      for (int k = 0; k < vecs[v].steps; k++) run_op(1'b1, 1'b0, 12'h0, 4'd0);
      if (vecs[v].enemy != 0) ddavers[3'(vecs[v].er)][3'(vecs[v].ec)] = vecs[v].enemy;
      run_op(1'b1, 1'b0, 12'h0, 4'd0);
      check($sformatf("vec%0d hits", v), op_hits, {31'd0, vecs[v].exp_hit});
      if (vecs[v].exp_hit)
        check($sformatf("vec%0d hitinfo", v), {last_row, last_col, last_match, 4'(hit_at)},
              {vecs[v].exp_hr, vecs[v].exp_hc, vecs[v].exp_match, 4'd1});
      check($sformatf("vec%0d slot", v), {bb_color[0], bb_x[0]}, {vecs[v].exp_col, vecs[v].exp_x});
      check($sformatf("vec%0d kill", v), kill_count, vecs[v].exp_kill);
    end

    // Spawn drops: full slots, bad row, zero color; row 10 still accepted.
    do_reset();
    clear_dd();
    run_op(1'b0, 1'b1, 12'hF00, 4'd0);
    run_op(1'b0, 1'b1, 12'h0F0, 4'd1);
    run_op(1'b0, 1'b1, 12'h00F, 4'd2);
    run_op(1'b0, 1'b1, 12'h00F, 4'd5);
    check("full drop", op_drops, 32'd1);
    check_slot("full", 0, 12'hF00, 4'd2, 4'd0);
    check_slot("full", 1, 12'h0F0, 4'd2, 4'd1);
    check_slot("full", 2, 12'h00F, 4'd2, 4'd2);
    do_reset();
    run_op(1'b0, 1'b1, 12'hF00, 4'd11);
    check("row11 drop", {op_drops, bb_color[0]}, {32'd1, 12'h000});
    run_op(1'b0, 1'b1, 12'h000, 4'd4);
    check("color0 drop", {op_drops, bb_color[0]}, {32'd1, 12'h000});
    run_op(1'b0, 1'b1, 12'h0F0, 4'd10);
    check("row10 ok", op_drops, 32'd0);
    check_slot("row10", 0, 12'h0F0, 4'd2, 4'd10);

    // Overwrite: second fire while the first is still pending.
    do_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; fire = 1'b1; fire_color = 12'hF00; blockieee = 4'd4;
    @(negedge clk);
    fire_color = 12'h0F0; blockieee = 4'd6;
    @(negedge clk);
    fire = 1'b0;
    op_drops = 0;
    for (int i = 0; i < 8; i++) begin
      if (fire_drop) op_drops++;
      @(negedge clk);
    end
    check("overwrite drops", op_drops, 32'd1);
    check_slot("overwrite", 0, 12'h0F0, 4'd2, 4'd6);
    check("overwrite idle", {bb_color[1], 3'd0, busy}, 32'd0);

    // Tick+fire together, extra tick during ADV1: ADV0-2, SPAWN, ADV0-2.
    do_reset();
    run_op(1'b0, 1'b1, 12'hF00, 4'd0);
    run_op(1'b0, 1'b1, 12'h0F0, 4'd0);
    tick = 1'b1; fire = 1'b1; fire_color = 12'h00F; blockieee = 4'd4;
    trace = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      tick = (i == 2);
      fire = 1'b0;
      trace = {trace[6:0], busy};
      if (i == 4) check("overlap pre-spawn", bb_color[2], 32'h0);
      if (i == 5) begin
        check_slot("overlap spawn", 2, 12'h00F, 4'd2, 4'd4);
        check("overlap adv1", bb_x[0], 32'd3);
      end
    end
    check("overlap busy trace", trace, 32'hFE);
    check_slot("overlap end", 0, 12'hF00, 4'd4, 4'd0);
    check_slot("overlap end", 1, 12'h0F0, 4'd4, 4'd0);
    check_slot("overlap end", 2, 12'h00F, 4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    check("overlap settles", busy, 32'd0);

    // Reset during ADV2 with a tick pending.
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) check_slot("midreset", s, 12'h0, 4'd0, 4'd0);
    check("midreset flags", {hit_valid, fire_drop, busy, kill_count}, 32'd0);
    busy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("midreset tick discarded", busy_seen, 32'd0);
    model_reset();

    // Kill counter saturates at 255.
    do_reset();
    clear_dd();
    ddavers[0][0] = 12'hF00;
    for (int k = 0; k < 90; k++) begin
      for (int j = 0; j < 3; j++) run_op(1'b0, 1'b1, 12'hF00, 4'd1);
      run_op(1'b1, 1'b0, 12'h0, 4'd0);
      run_op(1'b1, 1'b0, 12'h0, 4'd0);
    end
    check("kill saturates", kill_count, 32'd255);

    // Random operations against the reference model.
    do_reset();
    clear_dd();
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic t, f;
      logic [11:0] c;
      logic [3:0] r;
      if (n % 8 == 0)
        for (int rr = 0; rr < 5; rr++)
          for (int cc = 0; cc < 6; cc++)
            ddavers[rr][cc] = ($urandom_range(0, 9) < 6) ? 12'h000 : pick_color();
      kind = int'($urandom_range(0, 99));
      t = (kind < 50) || (kind >= 85);
      f = (kind >= 50);
      c = pick_color();
      r = 4'($urandom_range(0, 11));
      m_hits = 0; m_drops = 0;
      if (t) model_tick();
      if (f) model_fire(c, r);
      run_op(t, f, c, r);
      check($sformatf("rand%0d hits", n), op_hits, m_hits);
      check($sformatf("rand%0d drops", n), op_drops, m_drops);
      for (int s = 0; s < 3; s++) check_slot($sformatf("rand%0d", n), s, m_col[s], m_x[s], m_y[s]);
      check($sformatf("rand%0d kill", n), kill_count, m_kill);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
